// File: rtl/cpu_boot_ctrl_if.sv
// rtl/cpu_boot_ctrl_if.sv - host load stream, instruction RAM write port and CPU control bundle
interface cpu_boot_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              load_req;
  logic [ADDR_W:0]   load_len;
  logic              wr_valid;
  logic [31:0]       wr_data;
  logic              wr_ready;
  logic              iram_ena;
  logic              iram_wena;
  logic [ADDR_W-1:0] iram_waddr;
  logic [31:0]       iram_indata;
  logic              pc_ena;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output load_req, load_len, wr_valid, wr_data,
    input  wr_ready, iram_ena, iram_wena, iram_waddr, iram_indata,
    input  pc_ena, cpu_rst_n, busy, done, err
  );

  modport slave (
    input  load_req, load_len, wr_valid, wr_data,
    output wr_ready, iram_ena, iram_wena, iram_waddr, iram_indata,
    output pc_ena, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/cpu_boot_ctrl.sv
// rtl/cpu_boot_ctrl.sv - instruction memory boot/load controller with pipeline quiesce and reset release
module cpu_boot_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int QUIESCE_CYC = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic           clk,
  input  logic           rst,
  cpu_boot_ctrl_if.slave bus
);
  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_QUIESCE = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam int QW = (QUIESCE_CYC > 1) ? $clog2(QUIESCE_CYC) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [QW-1:0]   Q_LAST = QW'(QUIESCE_CYC - 1);
  localparam logic [IW-1:0]   I_LAST = IW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state;
  logic              rel_cnt;
  logic [QW-1:0]     q_cnt;
  logic [IW-1:0]     idle_cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   len;
  logic              handshake;
  logic              req_ok;

  // wr_ready is only ever high in LOAD, so a handshake implies LOAD
  assign handshake = bus.wr_valid & bus.wr_ready;
  assign req_ok    = (bus.load_len != '0) && (bus.load_len <= DEPTH);

  // Session FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_RELEASE;
      rel_cnt         <= 1'b0;
      q_cnt           <= '0;
      idle_cnt        <= '0;
      addr            <= '0;
      count           <= '0;
      len             <= '0;
      bus.pc_ena      <= 1'b0;
      bus.cpu_rst_n   <= 1'b0;
      bus.iram_ena    <= 1'b0;
      bus.iram_wena   <= 1'b0;
      bus.iram_waddr  <= '0;
      bus.iram_indata <= '0;
      bus.wr_ready    <= 1'b0;
      bus.busy        <= 1'b1;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.iram_wena <= 1'b0;
      case (state)
        S_RUN: begin
          bus.pc_ena    <= 1'b1;
          bus.cpu_rst_n <= 1'b1;
          bus.iram_ena  <= 1'b1;
          bus.wr_ready  <= 1'b0;
          bus.busy      <= 1'b0;
          if (bus.load_req) begin
            if (req_ok) begin
              len        <= bus.load_len;
              addr       <= '0;
              count      <= '0;
              q_cnt      <= '0;
              state      <= S_QUIESCE;
              bus.pc_ena <= 1'b0;
              bus.busy   <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        S_QUIESCE: begin
          // CPU keeps fetching while in-flight instructions drain
          if (q_cnt == Q_LAST) begin
            state         <= S_LOAD;
            idle_cnt      <= '0;
            bus.cpu_rst_n <= 1'b0;
            bus.iram_ena  <= 1'b0;
            bus.wr_ready  <= 1'b1;
          end else begin
            q_cnt <= q_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            bus.iram_ena    <= 1'b1;
            bus.iram_wena   <= 1'b1;
            bus.iram_waddr  <= addr;
            bus.iram_indata <= bus.wr_data;
            addr            <= addr + 1'b1;
            count           <= count + 1'b1;
            idle_cnt        <= '0;
            // The wrapped addr after a full-depth load is never written
            if (count + 1'b1 == len) begin
              bus.wr_ready <= 1'b0;
              bus.done     <= 1'b1;
              rel_cnt      <= 1'b0;
              state        <= S_RELEASE;
            end
          end else begin
            bus.iram_ena <= 1'b0;
            if (idle_cnt == I_LAST) begin
              bus.err      <= 1'b1;
              bus.wr_ready <= 1'b0;
              rel_cnt      <= 1'b0;
              state        <= S_RELEASE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: begin
          // RELEASE: two cycles of CPU reset, then restart at the reset PC
          bus.iram_ena  <= 1'b0;
          bus.wr_ready  <= 1'b0;
          bus.pc_ena    <= 1'b0;
          bus.cpu_rst_n <= 1'b0;
          bus.busy      <= 1'b1;
          if (rel_cnt) begin
            state         <= S_RUN;
            bus.pc_ena    <= 1'b1;
            bus.cpu_rst_n <= 1'b1;
            bus.iram_ena  <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            rel_cnt <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb/tb_cpu_boot_ctrl.sv - directed self-checking bench for cpu_boot_ctrl
module tb_cpu_boot_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  cpu_boot_ctrl_if #(.ADDR_W(4)) bus ();

  cpu_boot_ctrl #(.ADDR_W(4), .QUIESCE_CYC(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [4:0] len);
    bus.load_req = 1'b1;
    bus.load_len = len;
    tick();
    bus.load_req = 1'b0;
    check("req_busy", 32'(bus.busy), 32'd1);
    check("req_pc_ena", 32'(bus.pc_ena), 32'd0);
    check("quiesce_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    repeat (3) tick();
    check("quiesce_wr_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    check("load_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("load_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
  endtask

  task automatic expect_release_then_run();
    tick();
    check("rel_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("rel_busy", 32'(bus.busy), 32'd1);
    check("rel_wena", 32'(bus.iram_wena), 32'd0);
    tick();
    check("run_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    check("run_pc_ena", 32'(bus.pc_ena), 32'd1);
    check("run_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.load_req = 1'b0;
    bus.load_len = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;

    // reset held for 3 cycles, then released mid-cycle
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc_ena", 32'(bus.pc_ena), 32'd0);
    check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("rst_iram_ena", 32'(bus.iram_ena), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    check("c1_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    tick();
    check("c2_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("c2_busy", 32'(bus.busy), 32'd1);
    tick();
    check("c3_pc_ena", 32'(bus.pc_ena), 32'd1);
    check("c3_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    check("c3_busy", 32'(bus.busy), 32'd0);
    check("c3_iram_ena", 32'(bus.iram_ena), 32'd1);

    // normal load of 4 back-to-back words
    start_load(5'd4);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 32'hA0 + 32'(i);
      tick();
      check("nl_wena", 32'(bus.iram_wena), 32'd1);
      check("nl_waddr", 32'(bus.iram_waddr), 32'(i));
      check("nl_data", bus.iram_indata, 32'hA0 + 32'(i));
      check("nl_done", 32'(bus.done), (i == 3) ? 32'd1 : 32'd0);
      check("nl_wr_ready", 32'(bus.wr_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    bus.wr_valid = 1'b0;
    expect_release_then_run();

    // one word, then starve the stream until the idle timeout
    start_load(5'd3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h55;
    tick();
    check("to_waddr", 32'(bus.iram_waddr), 32'd0);
    check("to_data", bus.iram_indata, 32'h55);
    bus.wr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("to_err", 32'(bus.err), (k == 7) ? 32'd1 : 32'd0);
      check("to_wena", 32'(bus.iram_wena), 32'd0);
      check("to_done", 32'(bus.done), 32'd0);
    end
    check("to_wr_ready", 32'(bus.wr_ready), 32'd0);
    expect_release_then_run();
    check("to_err_clear", 32'(bus.err), 32'd0);

    // rejected requests leave the CPU running
    for (int b = 0; b < 2; b++) begin
      bus.load_req = 1'b1;
      bus.load_len = (b == 0) ? 5'd0 : 5'd17;
      tick();
      bus.load_req = 1'b0;
      check("bad_err", 32'(bus.err), 32'd1);
      check("bad_busy", 32'(bus.busy), 32'd0);
      check("bad_pc_ena", 32'(bus.pc_ena), 32'd1);
      tick();
      check("bad_err_pulse", 32'(bus.err), 32'd0);
      check("bad_busy2", 32'(bus.busy), 32'd0);
    end

    // full-depth load with an extra 17th word offered
    start_load(5'd16);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data = 32'h100 + 32'(i);
      tick();
      check("fd_waddr", 32'(bus.iram_waddr), 32'(i));
      check("fd_data", bus.iram_indata, 32'h100 + 32'(i));
      check("fd_done", 32'(bus.done), (i == 15) ? 32'd1 : 32'd0);
    end
    check("fd_wr_ready", 32'(bus.wr_ready), 32'd0);
    bus.wr_data = 32'hDEAD;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fd_extra_wena", 32'(bus.iram_wena), 32'd0);
      check("fd_extra_ready", 32'(bus.wr_ready), 32'd0);
    end
    check("fd_run_busy", 32'(bus.busy), 32'd0);
    bus.wr_valid = 1'b0;

    // asynchronous reset after 2 of 5 words
    start_load(5'd5);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.wr_data = 32'hC0 + 32'(i);
      tick();
      check("mr_waddr", 32'(bus.iram_waddr), 32'(i));
    end
    #2;
    rst = 1'b0;
    #1;
    bus.wr_valid = 1'b0;
    check("mr_pc_ena", 32'(bus.pc_ena), 32'd0);
    check("mr_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("mr_iram_ena", 32'(bus.iram_ena), 32'd0);
    check("mr_wena", 32'(bus.iram_wena), 32'd0);
    check("mr_waddr0", 32'(bus.iram_waddr), 32'd0);
    check("mr_data0", bus.iram_indata, 32'd0);
    check("mr_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("mr_c2_busy", 32'(bus.busy), 32'd1);
    tick();
    check("mr_c3_pc_ena", 32'(bus.pc_ena), 32'd1);
    start_load(5'd1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h77;
    tick();
    bus.wr_valid = 1'b0;
    check("mr_new_waddr", 32'(bus.iram_waddr), 32'd0);
    check("mr_new_data", bus.iram_indata, 32'h77);
    check("mr_new_done", 32'(bus.done), 32'd1);
    expect_release_then_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_boot_ctrl.md
# cpu_boot_ctrl

Instruction-memory boot and load controller for the pipelined CPU. It takes ownership of the instruction RAM write port from the debug/host side and quiesces the pipeline by dropping `pc_ena`. It streams words into instruction memory through a valid/ready handshake, then holds and releases the CPU reset so execution restarts at the reset PC. At all other times it leaves the CPU running with `pc_ena=1`, `iram_ena=1` and `iram_wena=0`.

## Interface
- `ADDR_W`, 10: instruction RAM word-address width; depth = 2^ADDR_W.
- `QUIESCE_CYC`, 4: cycles `pc_ena` is held low before the first write, to drain the pipeline.
- `TIMEOUT`, 1024: maximum idle cycles in LOAD between accepted words before an abort.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load_req` in 1: request a load session; sampled only in RUN.
- `load_len` in ADDR_W+1: number of words to load; sampled with `load_req`.
- `wr_valid` in 1: host word valid.
- `wr_data` in 32: host word.
- `wr_ready` out 1: controller accepts a word when `wr_valid & wr_ready`.
- `iram_ena` out 1: instruction RAM enable.
- `iram_wena` out 1: instruction RAM write strobe.
- `iram_waddr` out ADDR_W: write word address.
- `iram_indata` out 32: write data.
- `pc_ena` out 1: PC register enable.
- `cpu_rst_n` out 1: reset to the pipeline; active-low.
- `busy` out 1: high in any state other than RUN.
- `done` out 1: one-cycle pulse after the last word of a complete load is written.
- `err` out 1: one-cycle pulse on a rejected request or a timeout abort.

## Operation
- All outputs are registered. Reset values:
  - `pc_ena=0`, `cpu_rst_n=0`, `iram_ena=0`, `iram_wena=0`, `iram_waddr=0`, `iram_indata=0`
  - `wr_ready=0`, `busy=1`, `done=0`, `err=0`
  - state = RELEASE, release counter = 0
- States:
  - **RUN**
    - Outputs: `pc_ena=1`, `cpu_rst_n=1`, `iram_ena=1`, `iram_wena=0`, `wr_ready=0`, `busy=0`.
    - `load_req` with `1 <= load_len <= 2^ADDR_W`: latch length, clear address and word counters, go to QUIESCE.
    - `load_req` with `load_len==0` or `load_len > 2^ADDR_W`: pulse `err`, stay in RUN, CPU undisturbed.
  - **QUIESCE**
    - Outputs: `pc_ena=0`, `cpu_rst_n=1`, `wr_ready=0`.
    - Count QUIESCE_CYC cycles, then go to LOAD.
  - **LOAD**
    - Outputs: `pc_ena=0`, `cpu_rst_n=0`, `wr_ready=1` while accepted count < latched length.
    - On each handshake:
      - next cycle drive `iram_ena=1`, `iram_wena=1`, `iram_waddr=addr`, `iram_indata=wr_data`;
      - increment `addr` (ADDR_W bits) and the count;
      - clear the idle counter.
    - When the count reaches the length: `wr_ready` falls the following cycle, state goes to RELEASE, and `done` pulses on the cycle the final `iram_wena` is driven.
    - Idle counter increments on cycles without a handshake. When it reaches TIMEOUT: abort, pulse `err`, go to RELEASE. Words already written stay in RAM.
  - **RELEASE**
    - Outputs: `pc_ena=0`, `cpu_rst_n=0` for exactly 2 cycles, then go to RUN.
- `load_req` outside RUN is ignored.
- `wr_valid` outside LOAD is ignored; data is not consumed.
- Address arithmetic:
  - `iram_waddr` ranges 0..len-1.
  - A full-depth load (`len = 2^ADDR_W`) writes the last word at address 2^ADDR_W-1. The wrap of `addr` to 0 is never used for a write.
  - Length and count use ADDR_W+1 bits.
- Reset mid-operation (any state): all state and outputs return to their reset values immediately (asynchronous). The next session starts through RELEASE.

## Timing
- Reset deassertion:
  - RELEASE for 2 cycles;
  - RUN from cycle 3;
  - `cpu_rst_n` and `pc_ena` rise on the same edge.
- `load_req` in RUN at edge N:
  - `busy=1` and `pc_ena=0` from N+1;
  - QUIESCE occupies N+1..N+QUIESCE_CYC;
  - `wr_ready=1` from N+QUIESCE_CYC+1.
- Handshake at edge M: `iram_wena=1` with that word during cycle M+1. Write latency is 1 cycle.
- Throughput: one word per cycle when `wr_valid` is held high.
- Final word accepted at M:
  - `wr_ready=0` at M+1, and `iram_wena`/`done` during M+1;
  - RELEASE at M+1..M+2;
  - `cpu_rst_n=1` and `pc_ena=1` at M+3.
- Timeout: `err` pulses on the cycle RELEASE is entered.

## Test plan
- **Reset:** assert `rst=0` for 3 cycles, release.
  - Cycles 1-2: `cpu_rst_n=0`, `busy=1`.
  - Cycle 3: `pc_ena=1`, `cpu_rst_n=1`, `busy=0`.
- **Normal load:** `load_req` with `load_len=4`, words 0xA0..0xA3 streamed back-to-back.
  - 4 consecutive `iram_wena` pulses at addresses 0..3 with matching data.
  - `done` on the 4th write; CPU released 2 cycles later.
- **Backpressure and timeout:** `TIMEOUT=8`, `load_len=3`.
  - Send 1 word, then hold `wr_valid=0`.
  - Required: one write at address 0, `err` pulse after 8 idle cycles, RELEASE, RUN; no `done`.
- **Bad requests:**
  - `load_len=0`: `err` pulse, `busy` stays 0, `pc_ena` stays 1.
  - `load_len=2^ADDR_W+1`: same response.
- **Full depth:** `ADDR_W=4`, `load_len=16`.
  - Writes at addresses 0..15, last at 0xF; `wr_ready` drops after 16 words.
  - A 17th valid word is not accepted.
- **Reset mid-load:** assert `rst=0` after 2 of 5 words.
  - All outputs take reset values immediately.
  - After release: RELEASE then RUN; a new `load_req` starts again at address 0.
